// File: rtl/pipeline_pkg.sv
// Shared types and sizing helpers for the narrow/wide pipeline stages
// (collect and its mirrored distribute counterpart).
package pipeline_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collect_state_t;

  // Beat counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_collect_beat_counter.sv
// Modulo-NBEAT beat counter; flags the final beat of a block so the caller
// can frame on count alone.
module beat_counter
  import pipeline_pkg::*;
#(
  parameter int NBEAT = 8,
  parameter int CW    = cnt_width(NBEAT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == CW'(NBEAT - 1));

  // Advance on each accepted beat, wrapping after the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CW{1'b0}};
    end else if (inc) begin
      if (last) begin
        count <= {CW{1'b0}};
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_collect.sv
// Many-to-one stage: gathers NBEAT narrow beats into one wide word and holds
// it on a valid/ready output; the input is refilled in the same cycle the word leaves.
module pipeline_collect
  import pipeline_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NBEAT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [DW-1:0]       i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [NBEAT*DW-1:0] o_data,
  output logic                o_err
);

  localparam int CW = cnt_width(NBEAT);

  collect_state_t   state_r;
  logic [CW-1:0]    cnt_s;
  logic             final_s;
  logic             accept_s;
  logic             first_s;
  logic             mismatch_s;
  logic [NBEAT-1:0] slot_we_s;

  assign o_valid    = (state_r == HOLD);
  assign i_ready    = !o_valid || o_ready;
  assign accept_s   = i_valid && i_ready;
  assign first_s    = (cnt_s == {CW{1'b0}});
  assign mismatch_s = i_last ^ final_s;

  beat_counter #(
    .NBEAT (NBEAT),
    .CW    (CW)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_s),
    .count (cnt_s),
    .last  (final_s)
  );

  // Decode the current beat position into one write-enable per slot.
  always_comb begin
    slot_we_s = {NBEAT{1'b0}};
    for (int k = 0; k < NBEAT; k++) begin
      if (accept_s && (cnt_s == CW'(k))) begin
        slot_we_s[k] = 1'b1;
      end else begin
        slot_we_s[k] = 1'b0;
      end
    end
  end

  // COLLECT fills the word; HOLD presents it until the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s && final_s) begin
            state_r <= HOLD;
          end else begin
            state_r <= COLLECT;
          end
        end
        HOLD: begin
          if (o_ready) begin
            state_r <= COLLECT;
          end else begin
            state_r <= HOLD;
          end
        end
        default: state_r <= COLLECT;
      endcase
    end
  end

  // Assembly register doubles as the output word; no writes while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= {(NBEAT*DW){1'b0}};
    end else begin
      for (int k = 0; k < NBEAT; k++) begin
        if (slot_we_s[k]) begin
          o_data[k*DW +: DW] <= i_data;
        end
      end
    end
  end

  // Framing error accumulator, restarted by the first beat of each block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (accept_s) begin
      o_err <= (first_s ? 1'b0 : o_err) | mismatch_s;
    end else begin
      o_err <= o_err;
    end
  end

endmodule

// File: tb/tb_pipeline_collect.sv
// Bench for pipeline_collect: directed vectors on an 8x4 instance and a
// randomized scoreboard run on a 1x2 instance.
module tb_pipeline_collect;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: DW=8, NBEAT=4
  logic        a_i_valid, a_i_ready, a_i_last, a_o_valid, a_o_ready, a_o_err;
  logic [7:0]  a_i_data;
  logic [31:0] a_o_data;

  pipeline_collect #(.DW(8), .NBEAT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data), .i_last(a_i_last),
    .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .o_err(a_o_err)
  );

  // Instance B: DW=1, NBEAT=2
  logic       b_i_valid, b_i_ready, b_i_last, b_o_valid, b_o_ready, b_o_err;
  logic [0:0] b_i_data;
  logic [1:0] b_o_data;

  pipeline_collect #(.DW(1), .NBEAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data), .i_last(b_i_last),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_err(b_o_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  beat [4];
    logic [3:0]  last_mask;
    logic [31:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  // Push one beat into instance A; accepted at the following rising edge.
  task automatic a_beat(input logic [7:0] d, input logic l);
    @(negedge clk);
    a_i_valid = 1'b1;
    a_i_data  = d;
    a_i_last  = l;
  endtask

  task automatic a_idle_check(input string name, input logic [31:0] w, input logic e);
    @(negedge clk);
    a_i_valid = 1'b0;
    a_i_last  = 1'b0;
    #1;
    check({name, "_valid"}, 64'(a_o_valid), 64'(1));
    check({name, "_data"}, 64'(a_o_data), 64'(w));
    check({name, "_err"}, 64'(a_o_err), 64'(e));
  endtask

  // Randomized scoreboard state
  logic pend_d [$];
  logic pend_l [$];
  logic [1:0] exp_w [$];
  logic       exp_e [$];

  initial begin
    logic [1:0] prev_data;
    logic       prev_err;
    logic       prev_hold;
    int         acc_n;
    int         hs_n;
    logic [31:0] sw [3];

    vecs[0] = '{beat: '{8'h11, 8'h22, 8'h33, 8'h44}, last_mask: 4'b1000, exp_word: 32'h44332211, exp_err: 1'b0};
    vecs[1] = '{beat: '{8'haa, 8'hbb, 8'hcc, 8'hdd}, last_mask: 4'b0010, exp_word: 32'hddccbbaa, exp_err: 1'b1};
    vecs[2] = '{beat: '{8'h01, 8'h02, 8'h03, 8'h04}, last_mask: 4'b1000, exp_word: 32'h04030201, exp_err: 1'b0};
    vecs[3] = '{beat: '{8'hf0, 8'he1, 8'hd2, 8'hc3}, last_mask: 4'b0000, exp_word: 32'hc3d2e1f0, exp_err: 1'b1};
    vecs[4] = '{beat: '{8'h5a, 8'ha5, 8'h3c, 8'hc3}, last_mask: 4'b1111, exp_word: 32'hc33ca55a, exp_err: 1'b1};
    sw[0] = 32'h14131211;
    sw[1] = 32'h24232221;
    sw[2] = 32'h34333231;

    a_i_valid = 1'b0; a_i_data = 8'h00; a_i_last = 1'b0; a_o_ready = 1'b1;
    b_i_valid = 1'b0; b_i_data = 1'b0; b_i_last = 1'b0; b_o_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", 64'(a_o_valid), 64'(0));
    check("rst_o_data", 64'(a_o_data), 64'(0));
    check("rst_o_err", 64'(a_o_err), 64'(0));
    check("rst_i_ready", 64'(a_i_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven blocks with the downstream always ready
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) begin
        a_beat(vecs[v].beat[k], vecs[v].last_mask[k]);
        #1;
        if (k == 3) check($sformatf("vec%0d_latency", v), 64'(a_o_valid), 64'(0));
      end
      a_idle_check($sformatf("vec%0d", v), vecs[v].exp_word, vecs[v].exp_err);
    end

    // Backpressure: word held for 5 cycles while a beat waits at the input
    @(negedge clk);
    a_o_ready = 1'b0;
    for (int k = 0; k < 4; k++) a_beat(8'(8'h11 * (k + 1)), (k == 3));
    @(negedge clk);
    a_i_valid = 1'b1; a_i_data = 8'h99; a_i_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("hold%0d_valid", c), 64'(a_o_valid), 64'(1));
      check($sformatf("hold%0d_i_ready", c), 64'(a_i_ready), 64'(0));
      check($sformatf("hold%0d_data", c), 64'(a_o_data), 64'h44332211);
      @(negedge clk);
    end
    a_i_valid = 1'b0;
    a_o_ready = 1'b1;
    #1;
    check("hold_release_i_ready", 64'(a_i_ready), 64'(1));
    @(negedge clk);
    #1;
    check("hold_consumed", 64'(a_o_valid), 64'(0));

    // Continuous stream of 3 blocks, both sides always ready
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j < 12) begin
        a_i_valid = 1'b1;
        a_i_data  = {4'((j / 4) + 1), 4'((j % 4) + 1)};
        a_i_last  = ((j % 4) == 3);
      end else begin
        a_i_valid = 1'b0;
        a_i_last  = 1'b0;
      end
      #1;
      check($sformatf("stream%0d_i_ready", j), 64'(a_i_ready), 64'(1));
      check($sformatf("stream%0d_o_valid", j), 64'(a_o_valid), 64'((j >= 4) && ((j % 4) == 0)));
      if ((j >= 4) && ((j % 4) == 0)) begin
        check($sformatf("stream%0d_data", j), 64'(a_o_data), 64'(sw[(j / 4) - 1]));
        check($sformatf("stream%0d_err", j), 64'(a_o_err), 64'(0));
      end
    end
    @(negedge clk);
    #1;
    check("stream_drained", 64'(a_o_valid), 64'(0));

    // Asynchronous reset mid-block discards the partial word
    a_beat(8'hde, 1'b0);
    a_beat(8'had, 1'b0);
    @(negedge clk);
    a_i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_o_valid", 64'(a_o_valid), 64'(0));
    check("midrst_o_data", 64'(a_o_data), 64'(0));
    check("midrst_i_ready", 64'(a_i_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    a_beat(8'h55, 1'b0);
    a_beat(8'h66, 1'b0);
    a_beat(8'h77, 1'b0);
    a_beat(8'h88, 1'b1);
    a_idle_check("after_rst", 32'h88776655, 1'b0);

    // Randomized throttling on the 1x2 instance against a queue model
    acc_n = 0;
    hs_n = 0;
    prev_hold = 1'b0;
    prev_data = 2'b00;
    prev_err = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        check("rnd_hold_valid", 64'(b_o_valid), 64'(1));
        check("rnd_hold_data", 64'(b_o_data), 64'(prev_data));
        check("rnd_hold_err", 64'(b_o_err), 64'(prev_err));
      end
      if ((acc_n == 1000) && (exp_w.size() == 0) && (pend_d.size() == 0)) break;
      b_i_valid = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
      b_i_data  = 1'($urandom);
      b_i_last  = ((acc_n % 2) == 1) ^ ($urandom_range(0, 7) == 0);
      b_o_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_i_ready", 64'(b_i_ready), 64'(!b_o_valid || b_o_ready));
      if (b_o_valid && b_o_ready) begin
        hs_n++;
        if (exp_w.size() == 0) begin
          check("rnd_spurious_word", 64'(1), 64'(0));
        end else begin
          check($sformatf("rnd_word%0d_data", hs_n), 64'(b_o_data), 64'(exp_w.pop_front()));
          check($sformatf("rnd_word%0d_err", hs_n), 64'(b_o_err), 64'(exp_e.pop_front()));
        end
      end
      if (b_i_valid && b_i_ready) begin
        acc_n++;
        pend_d.push_back(b_i_data[0]);
        pend_l.push_back(b_i_last);
        if (pend_d.size() == 2) begin
          exp_w.push_back({pend_d[1], pend_d[0]});
          exp_e.push_back(pend_l[0] | !pend_l[1]);
          pend_d.delete();
          pend_l.delete();
        end
      end
      prev_hold = b_o_valid && !b_o_ready;
      prev_data = b_o_data;
      prev_err  = b_o_err;
    end
    b_i_valid = 1'b0;
    check("rnd_beats_accepted", 64'(acc_n), 64'(1000));
    check("rnd_words_out", 64'(hs_n), 64'(500));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
